tcm_mp_arb: RTL and testbench
=============================

// Module: tcm_mp_arb
// PURPOSE
//  Parametrised multi-port tightly coupled data memory; generalises single-bank DTCM to N requestors.
//  Typical requestors: core data IF, AXI slave, DMA.
//  Built-in arbiter grants one access per cycle and routes read data/valid only to the granted port.
//  Sits beside the core; replaces hard-wired priority muxing with selectable fixed or round-robin arbitration.
// PARAMETERS
//  NUM_PORTS   3     number of requestor ports (1..8)
//  DATA_WIDTH  32    word width in bits, multiple of 8
//  ADDR_WIDTH  32    byte-address width per port
//  DEPTH       8192  words of storage, power of 2
//  ARB_MODE    0     0 = fixed priority (port 0 highest), 1 = round-robin
// PORTS
//  clk        in   1                        clock
//  rst        in   1                        reset, synchronous, active-high
//  req_valid  in   NUM_PORTS                per-port access request
//  req_ready  out  NUM_PORTS                per-port grant; access accepted when valid&ready
//  req_wr     in   NUM_PORTS                per-port cmd, rd=0 wr=1
//  req_strb   in   NUM_PORTS*DATA_WIDTH/8   per-port byte strobes (writes only)
//  req_addr   in   NUM_PORTS*ADDR_WIDTH     per-port byte address
//  req_wdata  in   NUM_PORTS*DATA_WIDTH     per-port write data
//  rsp_valid  out  NUM_PORTS                per-port read data valid, 1-cycle pulse
//  rsp_rdata  out  NUM_PORTS*DATA_WIDTH     per-port read data; zero when own rsp_valid low
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, RR pointer=0. Memory array is not cleared.
//  - Grant: req_ready is one-hot or zero. It is combinational from req_valid and arbiter state.
//  - Grant rule: at most one grant per cycle. No bubble; back-to-back grants to any ports at full rate.
//  - Fixed mode: lowest-index valid port wins.
//  - RR mode: search starts at ptr. ptr <= granted+1 (mod NUM_PORTS) on each grant; ptr holds when idle.
//  - Requestor holds addr/wdata/wr/strb stable while valid&!ready. Dropping valid before ready is legal; nothing happens.
//  - Word index = addr[$clog2(DATA_WIDTH/8) +: $clog2(DEPTH)]. Higher bits ignored (aliasing).
//  - Write: byte lanes with strb=1 update at the grant edge. strb=0 write consumes the grant with no change. No rsp.
//  - Read: rsp_valid[g]=1 and rsp_rdata[g]=mem[idx] in cycle T+1 for a grant in cycle T.
//  - Read data is pre-write contents of that edge, i.e. mem state after all earlier grants.
//  - Write at T followed by read of same word at T+1 returns new data at T+2.
//  - rst high in cycle T: grant in T is void (no write, no rsp). Outputs take reset values at the next edge.
// CONFIGURATION
//  - Macro TCM_MP_OUT_REG_EN.
//  - Defined: extra output register stage; read latency 2 (rsp at T+2). Still fully pipelined, one rsp per cycle.
//  - Defined, reset: both stages clear on reset; an in-flight read is discarded.
//  - Undefined: latency 1 as above.
// STRUCTURE
//  - tcm_defines.vh holds ARB_FIXED/ARB_RR encodings, default widths/depth, and the latency localparam.
//  - The latency localparam depends on TCM_MP_OUT_REG_EN.
//  - Sub-module tcm_rr_arbiter: NUM_PORTS-wide fixed/RR arbiter with one-hot grant and pointer state.
//  - Top-level: arbiter, request mux, storage array, and rsp demux pipeline (port id + rd flag per stage).
// TESTING
//  1. Single port 0, write 0xDEADBEEF @0x10 strb=4'hF, read @0x10 -> rsp_valid[0] at T+1, rdata 0xDEADBEEF.
//  2. Write 0x11223344 then strb=4'b0101 write 0xAABBCCDD @0x20, read -> 0x11BB33DD.
//  3. Fixed mode, ports 0,1,2 valid every cycle for 3 cycles -> port 0 granted every cycle; ports 1,2 get req_ready=0.
//  4. RR mode, all 3 valid for 6 cycles -> grants 0,1,2,0,1,2; each read rsp only on its own port.
//  5. Port 1 read granted, rst asserted the same cycle -> no rsp_valid on any port; RR ptr=0 after reset.
//  6. Addr 0x8010 with DEPTH=8192, 32-bit words -> aliases word 4 (0x10); with TCM_MP_OUT_REG_EN, rsp arrives at T+2.

Source files
------------

// File: rtl/tcm_mp_arb_pkg.sv
// Shared types and defaults for the multi-port TCM and its arbiter.
// Read latency tracks TCM_MP_OUT_REG_EN (1 cycle without it, 2 with it).
package tcm_mp_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned TCM_NUM_PORTS  = 3;
    localparam int unsigned TCM_DATA_WIDTH = 32;
    localparam int unsigned TCM_ADDR_WIDTH = 32;
    localparam int unsigned TCM_DEPTH      = 8192;

`ifdef TCM_MP_OUT_REG_EN
    localparam int unsigned TCM_RD_LATENCY = 2;
`else
    localparam int unsigned TCM_RD_LATENCY = 1;
`endif

    // A single port still needs a 1-bit port id.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcm_mp_arb_if.sv
// Flattened per-port request/response bus of the multi-port TCM.
interface tcm_mp_arb_if #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [NUM_PORTS-1:0]              req_valid;
    logic [NUM_PORTS-1:0]              req_ready;
    logic [NUM_PORTS-1:0]              req_wr;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_strb;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata;
    logic [NUM_PORTS-1:0]              rsp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_wr, req_strb, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_strb, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/tcm_mp_arb_rr_arbiter.sv
// tcm_rr_arbiter: one-hot fixed-priority or round-robin grant with pointer state.
module tcm_rr_arbiter
    import tcm_mp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter arb_mode_e   MODE      = ARB_FIXED,
    parameter int unsigned PW        = ptr_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_any
);

    logic [PW-1:0] ptr;

    // A grant raised while rst is high would be voided anyway, so it is never raised.
    always_comb begin
        int unsigned cand;
        logic        found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (MODE == ARB_RR) begin
                cand = (int'(ptr) + i) % NUM_PORTS;
            end else begin
                cand = i;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gnt_idx     = PW'(cand);
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    assign gnt_any = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tcm_mp_arb.sv
// Multi-port tightly coupled data memory with built-in fixed/RR arbiter.
// TCM_MP_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module tcm_mp_arb
    import tcm_mp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = TCM_NUM_PORTS,
    parameter int unsigned DATA_WIDTH = TCM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = TCM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = TCM_DEPTH,
    parameter int unsigned ARB_MODE   = 0
) (
    input logic         clk,
    input logic         rst,
    tcm_mp_arb_if.slave bus
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PW    = ptr_width(NUM_PORTS);
    localparam arb_mode_e   MODE  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    logic [NUM_PORTS-1:0]  grant;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_any;

    logic                  sel_wr;
    logic [BYTES-1:0]      sel_strb;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [IDX_W-1:0]      sel_idx;
    logic                  unused_addr_bits;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  s1_vld;
    logic [PW-1:0]         s1_port;

    logic                  out_vld;
    logic [PW-1:0]         out_port;
    logic [DATA_WIDTH-1:0] out_data;

    tcm_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (MODE),
        .PW        (PW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.req_ready = grant;

    assign sel_wr    = bus.req_wr[gnt_idx];
    assign sel_strb  = bus.req_strb[gnt_idx*BYTES +: BYTES];
    assign sel_addr  = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Address bits above the word index alias onto the same storage.
    assign sel_idx          = sel_addr[OFF_W +: IDX_W];
    assign unused_addr_bits = ^sel_addr;

    always_ff @(posedge clk) begin
        if (gnt_any && sel_wr) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (sel_strb[b]) begin
                    mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
        if (gnt_any && !sel_wr) begin
            rd_data_q <= mem[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_port <= '0;
        end else begin
            s1_vld  <= gnt_any && !sel_wr;
            s1_port <= gnt_idx;
        end
    end

`ifdef TCM_MP_OUT_REG_EN
    logic                  s2_vld;
    logic [PW-1:0]         s2_port;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_port <= '0;
            s2_data <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_port <= s1_port;
            s2_data <= rd_data_q;
        end
    end

    assign out_vld  = s2_vld;
    assign out_port = s2_port;
    assign out_data = s2_data;
`else
    assign out_vld  = s1_vld;
    assign out_port = s1_port;
    assign out_data = rd_data_q;
`endif

    // Read data is steered to the owning port only; every other lane reads zero.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (out_vld) begin
            bus.rsp_valid[out_port]                          = 1'b1;
            bus.rsp_rdata[out_port*DATA_WIDTH +: DATA_WIDTH] = out_data;
        end
    end

endmodule

// File: tb/tb_tcm_mp_arb.sv
// Scoreboard bench: a fixed-priority and a round-robin instance driven by directed vectors.
module tb_tcm_mp_arb;

    localparam int N = 3;
`ifdef TCM_MP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    logic [N-1:0]    vld   [2];
    logic [N-1:0]    wr    [2];
    logic [N*4-1:0]  strb  [2];
    logic [N*32-1:0] addr  [2];
    logic [N*32-1:0] wdata [2];
    logic [N-1:0]    rdy   [2];
    logic [N-1:0]    rv    [2];
    logic [N*32-1:0] rd    [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m0[int];
    logic [31:0] m1[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcm_mp_arb_if #(.NUM_PORTS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    tcm_mp_arb_if #(.NUM_PORTS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

    assign bus0.req_valid = vld[0];
    assign bus0.req_wr    = wr[0];
    assign bus0.req_strb  = strb[0];
    assign bus0.req_addr  = addr[0];
    assign bus0.req_wdata = wdata[0];
    assign rdy[0]         = bus0.req_ready;
    assign rv[0]          = bus0.rsp_valid;
    assign rd[0]          = bus0.rsp_rdata;

    assign bus1.req_valid = vld[1];
    assign bus1.req_wr    = wr[1];
    assign bus1.req_strb  = strb[1];
    assign bus1.req_addr  = addr[1];
    assign bus1.req_wdata = wdata[1];
    assign rdy[1]         = bus1.req_ready;
    assign rv[1]          = bus1.rsp_valid;
    assign rd[1]          = bus1.rsp_rdata;

    tcm_mp_arb #(
        .NUM_PORTS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8192), .ARB_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    tcm_mp_arb #(
        .NUM_PORTS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8192), .ARB_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[14:2]);
    endfunction

    function automatic logic [31:0] mread(input int d, input int idx);
        if (d == 0) return m0.exists(idx) ? m0[idx] : 32'h0;
        return m1.exists(idx) ? m1[idx] : 32'h0;
    endfunction

    task automatic mwrite(input int d, input int idx, input logic [3:0] s, input logic [31:0] wd);
        logic [31:0] cur;
        cur = mread(d, idx);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
        end
        if (d == 0) m0[idx] = cur;
        else        m1[idx] = cur;
    endtask

    // Monitor: the queue head decides which port, if any, must respond this cycle.
    task automatic mon_sample(input int d);
        exp_t          e;
        logic          due_now;
        logic [N-1:0]  ev;
        logic [95:0]   edata;
        due_now = 1'b0;
        ev      = '0;
        edata   = '0;
        if (d == 0 && q0.size() > 0) begin e = q0[0]; due_now = (e.due == cyc); end
        if (d == 1 && q1.size() > 0) begin e = q1[0]; due_now = (e.due == cyc); end
        if (due_now) begin
            ev[e.port]              = 1'b1;
            edata[e.port*32 +: 32]  = e.data;
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        check(d == 0 ? "dut0_rsp_valid" : "dut1_rsp_valid", 96'(rv[d]), 96'(ev));
        check(d == 0 ? "dut0_rsp_rdata" : "dut1_rsp_rdata", rd[d], edata);
    endtask

    always @(negedge clk) begin
        mon_sample(0);
        mon_sample(1);
    end

    task automatic set_port(input int d, input int p, input logic v, input logic w,
                            input logic [3:0] s, input logic [31:0] a, input logic [31:0] wd);
        vld[d][p]          = v;
        wr[d][p]           = w;
        strb[d][p*4 +: 4]  = s;
        addr[d][p*32 +: 32] = a;
        wdata[d][p*32 +: 32] = wd;
    endtask

    task automatic idle(input int d);
        vld[d] = '0; wr[d] = '0; strb[d] = '0; addr[d] = '0; wdata[d] = '0;
    endtask

    // One cycle: check the grant, let the model accept it, then move past the edge.
    task automatic step(input int d, input logic [N-1:0] exp_g, input string name);
        exp_t e;
        int   idx;
        @(negedge clk);
        check(name, 96'(rdy[d]), 96'(exp_g));
        if (!rst) begin
            for (int p = 0; p < N; p++) begin
                if (exp_g[p]) begin
                    idx = widx(addr[d][p*32 +: 32]);
                    if (wr[d][p]) begin
                        mwrite(d, idx, strb[d][p*4 +: 4], wdata[d][p*32 +: 32]);
                    end else begin
                        e.port = p;
                        e.data = mread(d, idx);
                        e.due  = cyc + LAT;
                        if (d == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int d, input int n);
        idle(d);
        repeat (n) step(d, 3'b000, "idle_ready");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(0);
        idle(1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset: valid requests are never granted.
        for (int p = 0; p < N; p++) set_port(0, p, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        step(0, 3'b000, "rst_ready");
        step(0, 3'b000, "rst_ready");
        rst = 1'b0;
        idle(0);
        step(0, 3'b000, "idle_ready");

        // 1: full write then read of the same word.
        set_port(0, 0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        step(0, 3'b001, "t1_wr_grant");
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        step(0, 3'b001, "t1_rd_grant");

        // 2: partial-strobe merge, expected 0x11BB33DD.
        set_port(0, 0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
        step(0, 3'b001, "t2_wr_full");
        set_port(0, 0, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        step(0, 3'b001, "t2_wr_part");
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        step(0, 3'b001, "t2_rd_grant");

        // 3: fixed priority, port 0 wins while it keeps requesting.
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_port(0, 1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        set_port(0, 2, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        repeat (3) step(0, 3'b001, "t3_fixed_grant");
        set_port(0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(0, 3'b010, "t3_fixed_next");

        // 6: high address bits alias onto word 4.
        idle(0);
        set_port(0, 2, 1'b1, 1'b1, 4'hF, 32'h8010, 32'hCAFEF00D);
        step(0, 3'b100, "t6_alias_wr");
        idle(0);
        set_port(0, 1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        step(0, 3'b010, "t6_alias_rd");
        idle_cycles(0, LAT + 1);

        // 4: round-robin rotation, pointer ends at 0 after the three writes.
        set_port(1, 0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hA0A0A0A0);
        step(1, 3'b001, "t4_wr0");
        idle(1);
        set_port(1, 1, 1'b1, 1'b1, 4'hF, 32'h44, 32'hB1B1B1B1);
        step(1, 3'b010, "t4_wr1");
        idle(1);
        set_port(1, 2, 1'b1, 1'b1, 4'hF, 32'h48, 32'hC2C2C2C2);
        step(1, 3'b100, "t4_wr2");
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        set_port(1, 2, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
        repeat (2) begin
            step(1, 3'b001, "t4_rr_g0");
            step(1, 3'b010, "t4_rr_g1");
            step(1, 3'b100, "t4_rr_g2");
        end

        // Pointer holds across idle cycles.
        idle_cycles(1, 2);
        set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        set_port(1, 2, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
        step(1, 3'b010, "rr_hold_g1");
        step(1, 3'b100, "rr_hold_g2");
        idle_cycles(1, LAT + 1);

        // 5: grant voided by reset, pointer returns to 0.
        set_port(1, 0, 1'b1, 1'b1, 4'hF, 32'h4C, 32'h55AA55AA);
        step(1, 3'b001, "t5_pre_wr");
        idle(1);
        set_port(1, 1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        rst = 1'b1;
        step(1, 3'b000, "t5_rst_grant");
        rst = 1'b0;
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 32'h4C, 32'h0);
        set_port(1, 2, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
        step(1, 3'b001, "t5_ptr_zero");
        step(1, 3'b010, "t5_ptr_next");
        idle_cycles(1, LAT + 2);
        idle_cycles(0, 1);

        check("scoreboard_empty", 96'(q0.size() + q1.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
